program_memory_arbiter: RTL and testbench
=========================================

PROGRAM_MEMORY_ARBITER -- requirements
Module: program_memory_arbiter

Interface
REQ-001 SHALL have parameters, one per line: name, default, meaning:
  RAM_WIDTH  32  data word width
  RAM_ADDR_BITS  9  word address width
  STARVE_LIMIT  4  consecutive denied fetch cycles before fetch is forced a grant (range 1..15)
REQ-002 SHALL have ports, one per line: name, direction, width, meaning:
  clock  in  1  single clock, rising edge
  reset_n  in  1  asynchronous active-low reset
  f_req  in  1  fetch read request
  f_addr  in  RAM_ADDR_BITS  fetch address
  f_gnt  out  1  fetch request accepted this cycle
  f_rvalid  out  1  rdata holds fetch read result
  l_req  in  1  loader request
  l_we  in  1  loader write (1) / read (0)
  l_addr  in  RAM_ADDR_BITS  loader address
  l_wdata  in  RAM_WIDTH  loader write data
  l_lock  in  1  loader holds memory exclusively (program load)
  l_gnt  out  1  loader request accepted this cycle
  l_rvalid  out  1  rdata holds loader read result
  rdata  out  RAM_WIDTH  read data, passthrough of mem_rdata
  locked  out  1  arbiter in LOCKED state
  mem_en, mem_we  out  1 each  RAM enable / write enable
  mem_addr  out  RAM_ADDR_BITS  RAM address
  mem_wdata  out  RAM_WIDTH  RAM write data
  mem_rdata  in  RAM_WIDTH  RAM output, valid one cycle after enabled access
REQ-003 SHALL treat the clock as "clock" and the reset as "reset_n", asynchronous active-low; no other clock or reset.

Function
REQ-004 SHALL drive the RAM with at most one access per cycle; mem_en = f_gnt | l_gnt; f_gnt and l_gnt SHALL never both be 1.
REQ-005 SHALL generate grants combinationally from current requests and registered state; the granted requester's addr/we/wdata SHALL drive mem_* the same cycle; mem_we = l_gnt & l_we; fetch never writes.
REQ-006 SHALL have FSM states SHARED and LOCKED.
REQ-007 SHARED: only one requester active -> it is granted; both active -> loader granted, unless starve counter == STARVE_LIMIT, then fetch granted.
REQ-008 Starve counter (4 bits): reset 0; cleared on f_gnt or when f_req = 0; incremented when f_req = 1 and f_gnt = 0; saturates at STARVE_LIMIT.
REQ-009 SHARED -> LOCKED when l_lock = 1 and no fetch grant issued this cycle; LOCKED -> SHARED when l_lock = 0. Transition takes effect next cycle.
REQ-010 LOCKED: f_gnt = 0 regardless of starve counter; l_gnt = l_req; locked = 1; starve counter held at 0.
REQ-011 f_rvalid SHALL be a registered copy of (f_gnt & ~mem_we) and l_rvalid of (l_gnt & ~l_we): asserted exactly one cycle after the accepted read; loader writes produce no rvalid.
REQ-012 rdata SHALL equal mem_rdata unregistered; rdata meaningful only when an rvalid is 1.
REQ-013 Back-to-back grants SHALL sustain one access per cycle, including alternating requesters; f_rvalid and l_rvalid never both 1.
REQ-014 Requester that is not granted SHALL hold its request and payload stable; arbiter keeps no request queue.
REQ-015 Read-then-write to same address on consecutive cycles SHALL return the old data (RAM read-first behaviour), no arbiter forwarding.

Reset
REQ-016 reset_n = 0 SHALL immediately force: state SHARED, starve counter 0, f_rvalid = l_rvalid = 0, locked = 0.
REQ-017 While reset_n = 0, f_gnt, l_gnt, mem_en, mem_we SHALL be 0 regardless of requests.
REQ-018 Reset asserted mid-read SHALL discard the pending rvalid; first grant possible in the first cycle with reset_n = 1.

Verification
REQ-019 Fetch only, f_addr = 0,1,2 on consecutive cycles -> f_gnt = 1 each cycle, f_rvalid = 1 cycles 1..3 with rdata = mem[0..2].
REQ-020 f_req and l_req (read) held continuously, STARVE_LIMIT = 4 -> grant pattern L,L,L,L,F repeating; never 5 consecutive fetch denials.
REQ-021 l_lock = 1 with f_req = 1 for 10 cycles, loader writes 0xDEADBEEF to addr 5 -> f_gnt = 0 throughout LOCKED, mem_we = 1 once; after l_lock = 0, fetch of addr 5 returns 0xDEADBEEF.
REQ-022 Loader write to addr 3 then fetch addr 3 next cycle -> fetch returns new value; read addr 3 and write addr 3 back-to-back -> read returns old value.
REQ-023 reset_n dropped the cycle after a fetch grant -> f_rvalid stays 0, all grants 0 until release, starve counter 0 after release.
REQ-024 Random f_req/l_req/l_we/l_lock for 10k cycles -> assertions: grants mutually exclusive, rvalid latency 1, no fetch grant in LOCKED, starve bound held in SHARED.

Source files
------------

// File: rtl/program_memory_arbiter.sv
// Two-requester arbiter for a single-port program RAM: instruction fetch vs. program loader.
// Loader wins contention, fetch is forced through after STARVE_LIMIT denials; l_lock gives the loader exclusive use.
module program_memory_arbiter #(
  parameter int RAM_WIDTH     = 32,
  parameter int RAM_ADDR_BITS = 9,
  parameter int STARVE_LIMIT  = 4
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     f_req,
  input  logic [RAM_ADDR_BITS-1:0] f_addr,
  output logic                     f_gnt,
  output logic                     f_rvalid,
  input  logic                     l_req,
  input  logic                     l_we,
  input  logic [RAM_ADDR_BITS-1:0] l_addr,
  input  logic [RAM_WIDTH-1:0]     l_wdata,
  input  logic                     l_lock,
  output logic                     l_gnt,
  output logic                     l_rvalid,
  output logic [RAM_WIDTH-1:0]     rdata,
  output logic                     locked,
  output logic                     mem_en,
  output logic                     mem_we,
  output logic [RAM_ADDR_BITS-1:0] mem_addr,
  output logic [RAM_WIDTH-1:0]     mem_wdata,
  input  logic [RAM_WIDTH-1:0]     mem_rdata
);

  typedef enum logic {SHARED, LOCKED} state_t;

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  state_t     state_q, state_d;
  logic [3:0] starve_q, starve_d;

  // Grants are gated by reset_n so nothing reaches the RAM while reset is held.
  always_comb begin
    f_gnt    = 1'b0;
    l_gnt    = 1'b0;
    state_d  = state_q;
    starve_d = 4'd0;
    if (reset_n) begin
      case (state_q)
        SHARED: begin
          if (f_req && l_req) begin
            f_gnt = (starve_q == LIMIT);
            l_gnt = ~f_gnt;
          end else begin
            f_gnt = f_req;
            l_gnt = l_req;
          end
          if (f_req && !f_gnt)
            starve_d = (starve_q == LIMIT) ? starve_q : starve_q + 4'd1;
          if (l_lock && !f_gnt)
            state_d = LOCKED;
        end
        LOCKED: begin
          l_gnt = l_req;
          if (!l_lock)
            state_d = SHARED;
        end
        default: state_d = SHARED;
      endcase
    end
  end

  assign mem_en    = f_gnt | l_gnt;
  assign mem_we    = l_gnt & l_we;
  assign mem_addr  = f_gnt ? f_addr : l_addr;
  assign mem_wdata = l_wdata;
  assign rdata     = mem_rdata;
  assign locked    = (state_q == LOCKED);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= SHARED;
      starve_q <= 4'd0;
      f_rvalid <= 1'b0;
      l_rvalid <= 1'b0;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
      f_rvalid <= f_gnt & ~mem_we;
      l_rvalid <= l_gnt & ~l_we;
    end
  end

endmodule

// File: tb/tb_program_memory_arbiter.sv
// Bench for program_memory_arbiter: read-first RAM model, per-cycle reference model check,
// and directed scenarios with literal expectations, then a randomised soak.
module tb_program_memory_arbiter;
  localparam int AW = 9;
  localparam int DW = 32;
  localparam int SL = 4;

  logic          clock = 1'b0;
  logic          reset_n;
  logic          f_req, l_req, l_we, l_lock;
  logic [AW-1:0] f_addr, l_addr;
  logic [DW-1:0] l_wdata;
  logic          f_gnt, f_rvalid, l_gnt, l_rvalid, locked;
  logic          mem_en, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata, rdata;

  int checks = 0;
  int errors = 0;

  program_memory_arbiter #(.RAM_WIDTH(DW), .RAM_ADDR_BITS(AW), .STARVE_LIMIT(SL)) dut (
    .clock(clock), .reset_n(reset_n),
    .f_req(f_req), .f_addr(f_addr), .f_gnt(f_gnt), .f_rvalid(f_rvalid),
    .l_req(l_req), .l_we(l_we), .l_addr(l_addr), .l_wdata(l_wdata), .l_lock(l_lock),
    .l_gnt(l_gnt), .l_rvalid(l_rvalid), .rdata(rdata), .locked(locked),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  always #5 clock = ~clock;

  function automatic logic [DW-1:0] init_word(int i);
    return 32'h1000_0000 + 32'(3 * i);
  endfunction

  // Synchronous read-first RAM
  logic [DW-1:0] ram [512];
  initial for (int i = 0; i < 512; i++) ram[i] <= init_word(i);
  always @(posedge clock)
    if (mem_en) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      else        mem_rdata     <= ram[mem_addr];
    end

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: who may use the RAM this cycle, how long fetch has waited, what data comes back.
  logic [DW-1:0] ref_mem [512];
  initial for (int i = 0; i < 512; i++) ref_mem[i] = init_word(i);
  bit            m_locked = 0;
  int            m_wait = 0;
  bit            exp_fv = 0, exp_lv = 0;
  logic [DW-1:0] exp_rd = '0;
  int            run = 0;

  always @(negedge clock) begin
    bit e_fg, e_lg;
    if (!reset_n) begin
      chk("rst_f_gnt", f_gnt, 0);   chk("rst_l_gnt", l_gnt, 0);
      chk("rst_mem_en", mem_en, 0); chk("rst_mem_we", mem_we, 0);
      chk("rst_f_rvalid", f_rvalid, 0); chk("rst_l_rvalid", l_rvalid, 0);
      chk("rst_locked", locked, 0);
      m_locked = 0; m_wait = 0; exp_fv = 0; exp_lv = 0; run = 0;
    end else begin
      if (m_locked)               begin e_fg = 0; e_lg = l_req; end
      else if (f_req && l_req)    begin e_fg = (m_wait >= SL); e_lg = !e_fg; end
      else                        begin e_fg = f_req; e_lg = l_req; end
      chk("f_gnt", f_gnt, e_fg);
      chk("l_gnt", l_gnt, e_lg);
      chk("mem_en", mem_en, e_fg | e_lg);
      chk("mem_we", mem_we, e_lg & l_we);
      if (e_fg | e_lg) chk("mem_addr", mem_addr, e_fg ? f_addr : l_addr);
      if (e_lg & l_we) chk("mem_wdata", mem_wdata, l_wdata);
      chk("f_rvalid", f_rvalid, exp_fv);
      chk("l_rvalid", l_rvalid, exp_lv);
      chk("locked", locked, m_locked);
      if (exp_fv | exp_lv) chk("rdata", rdata, exp_rd);
      chk("gnt_excl", f_gnt & l_gnt, 0);
      chk("rvalid_excl", f_rvalid & l_rvalid, 0);
      if (f_req && !f_gnt && !locked) run++; else run = 0;
      chk("starve_bound", 32'(run > SL), 0);
      // advance model to the next cycle
      exp_fv = e_fg;
      exp_lv = e_lg & !l_we;
      if (e_fg)             exp_rd = ref_mem[f_addr];
      else if (e_lg && !l_we) exp_rd = ref_mem[l_addr];
      if (e_lg && l_we) ref_mem[l_addr] = l_wdata;
      m_wait   = (f_req && !e_fg && !m_locked) ? m_wait + 1 : 0;
      m_locked = m_locked ? l_lock : (l_lock && !e_fg);
    end
  end

  task automatic step();
    @(posedge clock); #1;
  endtask

  task automatic drv(input logic f, input int fa, input logic l, input logic we,
                     input int la, input logic [DW-1:0] wd, input logic lk);
    f_req = f; f_addr = AW'(fa); l_req = l; l_we = we; l_addr = AW'(la); l_wdata = wd; l_lock = lk;
  endtask

  initial begin
    int wcount;
    bit lk;
    reset_n = 0;
    drv(1, 0, 1, 1, 0, 0, 0);
    @(negedge clock);
    chk("lit_rst_fgnt", f_gnt, 0); chk("lit_rst_lgnt", l_gnt, 0); chk("lit_rst_locked", locked, 0);
    step(); reset_n = 1;

    // fetch-only stream, addresses 0,1,2
    for (int i = 0; i < 3; i++) begin
      drv(1, i, 0, 0, 0, 0, 0);
      @(negedge clock);
      chk("lit_stream_fgnt", f_gnt, 1);
      if (i > 0) begin
        chk("lit_stream_fv", f_rvalid, 1);
        chk("lit_stream_rd", rdata, i == 1 ? 32'h1000_0000 : 32'h1000_0003);
      end
      step();
    end
    drv(0, 0, 0, 0, 0, 0, 0);
    @(negedge clock); chk("lit_stream_fv", f_rvalid, 1); chk("lit_stream_rd", rdata, 32'h1000_0006);
    step();

    // contention: L,L,L,L,F repeating
    for (int k = 0; k < 15; k++) begin
      drv(1, 7, 1, 0, 8, 0, 0);
      @(negedge clock);
      chk("lit_starve_f", f_gnt, (k % 5) == 4);
      chk("lit_starve_l", l_gnt, (k % 5) != 4);
      step();
    end
    drv(0, 0, 0, 0, 0, 0, 0); step();

    // locked program load
    drv(1, 5, 1, 0, 0, 0, 1);
    @(negedge clock); chk("lit_lock_l0", l_gnt, 1); chk("lit_lock_f0", f_gnt, 0); chk("lit_lock_st0", locked, 0);
    step();
    wcount = 0;
    for (int k = 1; k < 10; k++) begin
      drv(1, 5, k == 4, 1, 5, 32'hDEAD_BEEF, 1);
      @(negedge clock);
      chk("lit_lock_f", f_gnt, 0); chk("lit_lock_st", locked, 1);
      wcount += int'(mem_we);
      step();
    end
    chk("lit_lock_wcount", wcount, 1);
    drv(1, 5, 0, 0, 0, 0, 0);
    @(negedge clock); chk("lit_unlock_f", f_gnt, 0); chk("lit_unlock_st", locked, 1);
    step();
    @(negedge clock); chk("lit_unlock_f2", f_gnt, 1); chk("lit_unlock_st2", locked, 0);
    step();
    drv(0, 0, 0, 0, 0, 0, 0);
    @(negedge clock); chk("lit_unlock_fv", f_rvalid, 1); chk("lit_unlock_rd", rdata, 32'hDEAD_BEEF);
    step();

    // write then read; read then write (read-first)
    drv(0, 0, 1, 1, 3, 32'h1234_5678, 0); step();
    drv(1, 3, 0, 0, 0, 0, 0); step();
    drv(0, 0, 0, 0, 0, 0, 0);
    @(negedge clock); chk("lit_wr_rd", rdata, 32'h1234_5678);
    step();
    drv(1, 3, 0, 0, 0, 0, 0); step();
    drv(0, 0, 1, 1, 3, 32'hCAFE_F00D, 0);
    @(negedge clock); chk("lit_rd_wr_fv", f_rvalid, 1); chk("lit_rd_wr_old", rdata, 32'h1234_5678);
    step();
    drv(1, 3, 0, 0, 0, 0, 0); step();
    drv(0, 0, 0, 0, 0, 0, 0);
    @(negedge clock); chk("lit_rd_new", rdata, 32'hCAFE_F00D);
    step();

    // reset the cycle after a fetch grant, then a reset with fetch partly starved
    for (int k = 0; k < 5; k++) begin drv(1, 1, 1, 0, 2, 0, 0); step(); end
    reset_n = 0;
    @(negedge clock); chk("lit_rst_fv", f_rvalid, 0); chk("lit_rst_en", mem_en, 0);
    step(); step(); reset_n = 1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clock); chk("lit_post_rst_l", l_gnt, 1); step();
    end
    reset_n = 0; step(); reset_n = 1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clock); chk("lit_post_rst_f", f_gnt, k == 4); step();
    end

    // randomised soak with sticky lock episodes
    lk = 0;
    for (int n = 0; n < 10000; n++) begin
      if ($urandom_range(0, 39) == 0) lk = ~lk;
      drv($urandom_range(0, 3) != 0, $urandom_range(0, 15), $urandom_range(0, 3) != 0,
          $urandom_range(0, 2) == 0, $urandom_range(0, 15), $urandom, lk);
      step();
    end
    drv(0, 0, 0, 0, 0, 0, 0); step(); step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
